// File: rtl/tri_setup.sv
// Triangle setup: turns three screen-space vertices into packed edge-equation
// words {A, B, C}, normalises winding and commits only on frame_start.
module tri_setup #(
  parameter int CW = 18,
  parameter int XW = 10
) (
  input  logic            vga_clk,
  input  logic            vga_rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XW-1:0]   in_x0,
  input  logic [XW-1:0]   in_y0,
  input  logic [XW-1:0]   in_x1,
  input  logic [XW-1:0]   in_y1,
  input  logic [XW-1:0]   in_x2,
  input  logic [XW-1:0]   in_y2,
  input  logic            frame_start,
  output logic [3*CW-1:0] e0,
  output logic [3*CW-1:0] e1,
  output logic [3*CW-1:0] e2,
  output logic            busy,
  output logic            updated,
  output logic            degenerate,
  output logic            err
);

  localparam int DW = XW + 1;
  localparam int PW = 2*XW + 3;
  localparam int EW = 3*CW;
  localparam logic [EW-1:0] NOHIT = {{(2*CW){1'b0}}, {CW{1'b1}}};

  typedef enum logic [2:0] {IDLE, MUL, SUM, FIX, PENDING} state_t;
  state_t state, state_nx;

  logic [XW-1:0]          vx [3];
  logic [XW-1:0]          vy [3];
  logic [2:0]             cnt;
  logic signed [DW-1:0]   da [3];
  logic signed [DW-1:0]   db [3];
  logic signed [PW-1:0]   prod [6];
  logic signed [PW-1:0]   cc [3];
  logic signed [PW-1:0]   area;
  logic [EW-1:0]          pend [3];
  logic                   pend_degen;
  logic [XW-1:0]          ma, mb;
  logic signed [2*DW-1:0] mp;
  logic signed [PW-1:0]   fld [9];
  logic                   fit;

  // Single shared multiplier; operand pair chosen by the MUL step counter.
  always_comb begin
    ma = vx[0];
    mb = vy[1];
    case (cnt)
      3'd1: begin ma = vx[1]; mb = vy[0]; end
      3'd2: begin ma = vx[1]; mb = vy[2]; end
      3'd3: begin ma = vx[2]; mb = vy[1]; end
      3'd4: begin ma = vx[2]; mb = vy[0]; end
      3'd5: begin ma = vx[0]; mb = vy[2]; end
      default: ;
    endcase
    mp = $signed({1'b0, ma}) * $signed({1'b0, mb});
  end

  // Fields in A,B,C order per edge, winding-normalised, then range-checked.
  always_comb begin
    fit = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      fld[3*i]   = {{(PW-DW){da[i][DW-1]}}, da[i]};
      fld[3*i+1] = {{(PW-DW){db[i][DW-1]}}, db[i]};
      fld[3*i+2] = cc[i];
    end
    if (area[PW-1]) begin
      for (int unsigned k = 0; k < 9; k++) fld[k] = -fld[k];
    end
    for (int unsigned k = 0; k < 9; k++) begin
      if (!(fld[k][PW-1:CW-1] == '0 || fld[k][PW-1:CW-1] == '1)) fit = 1'b0;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (vga_rst) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = MUL;
      MUL:     if (cnt == 3'd5) state_nx = SUM;
      SUM:     state_nx = FIX;
      FIX:     state_nx = fit ? PENDING : IDLE;
      PENDING: if (frame_start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
  end

  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      e0         <= NOHIT;
      e1         <= '0;
      e2         <= '0;
      updated    <= 1'b0;
      degenerate <= 1'b0;
      err        <= 1'b0;
      cnt        <= '0;
    end else begin
      updated    <= 1'b0;
      degenerate <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (in_valid) begin
            vx[0] <= in_x0; vy[0] <= in_y0;
            vx[1] <= in_x1; vy[1] <= in_y1;
            vx[2] <= in_x2; vy[2] <= in_y2;
          end
        end
        MUL: begin
          prod[cnt] <= {{(PW-2*DW){mp[2*DW-1]}}, mp};
          cnt       <= cnt + 3'd1;
          da[0] <= $signed({1'b0, vy[0]}) - $signed({1'b0, vy[1]});
          da[1] <= $signed({1'b0, vy[1]}) - $signed({1'b0, vy[2]});
          da[2] <= $signed({1'b0, vy[2]}) - $signed({1'b0, vy[0]});
          db[0] <= $signed({1'b0, vx[1]}) - $signed({1'b0, vx[0]});
          db[1] <= $signed({1'b0, vx[2]}) - $signed({1'b0, vx[1]});
          db[2] <= $signed({1'b0, vx[0]}) - $signed({1'b0, vx[2]});
        end
        SUM: begin
          cc[0] <= prod[0] - prod[1];
          cc[1] <= prod[2] - prod[3];
          cc[2] <= prod[4] - prod[5];
          area  <= (prod[0] - prod[1]) + (prod[2] - prod[3]) + (prod[4] - prod[5]);
        end
        FIX: begin
          if (fit) begin
            pend[0]    <= {fld[0][CW-1:0], fld[1][CW-1:0], fld[2][CW-1:0]};
            pend[1]    <= {fld[3][CW-1:0], fld[4][CW-1:0], fld[5][CW-1:0]};
            pend[2]    <= {fld[6][CW-1:0], fld[7][CW-1:0], fld[8][CW-1:0]};
            pend_degen <= (area == '0);
          end else begin
            err <= 1'b1;
          end
        end
        PENDING: begin
          if (frame_start) begin
            updated <= 1'b1;
            if (pend_degen) begin
              e0         <= NOHIT;
              e1         <= '0;
              e2         <= '0;
              degenerate <= 1'b1;
            end else begin
              e0 <= pend[0];
              e1 <= pend[1];
              e2 <= pend[2];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_setup.sv
// Directed and randomized checks of tri_setup against an integer edge-equation
// model: handshake, winding, degenerate/overflow handling and commit timing.
module tb_tri_setup;
  localparam int CW = 18;
  localparam int XW = 10;
  localparam logic [53:0] NOHIT = {36'd0, 18'h3FFFF};

  logic          clk = 1'b0;
  logic          vga_rst, in_valid, frame_start;
  logic [XW-1:0] in_x0, in_y0, in_x1, in_y1, in_x2, in_y2;
  logic          in_ready, busy, updated, degenerate, err;
  logic [53:0]   e0, e1, e2;

  int nvec = 0;
  int nerr = 0;

  int          tx [3];
  int          ty [3];
  logic [53:0] exp_e [3];
  logic [53:0] cur_e [3];
  bit          exp_deg, exp_err;

  tri_setup #(.CW(CW), .XW(XW)) dut (
    .vga_clk(clk), .vga_rst(vga_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x0(in_x0), .in_y0(in_y0), .in_x1(in_x1), .in_y1(in_y1),
    .in_x2(in_x2), .in_y2(in_y2), .frame_start(frame_start),
    .e0(e0), .e1(e1), .e2(e2), .busy(busy), .updated(updated),
    .degenerate(degenerate), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nvec++;
    assert (obs === expv)
    else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Edge equations straight from the vertex formulas, in plain integers.
  function automatic void ref_model();
    int a [3];
    int b [3];
    int c [3];
    int ar;
    ar = 0;
    for (int i = 0; i < 3; i++) begin
      int j;
      j = (i + 1) % 3;
      a[i] = ty[i] - ty[j];
      b[i] = tx[j] - tx[i];
      c[i] = tx[i] * ty[j] - tx[j] * ty[i];
      ar += c[i];
    end
    exp_deg = (ar == 0);
    exp_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (ar < 0) begin
        a[i] = -a[i]; b[i] = -b[i]; c[i] = -c[i];
      end
      if (a[i] < -131072 || a[i] > 131071) exp_err = 1'b1;
      if (b[i] < -131072 || b[i] > 131071) exp_err = 1'b1;
      if (c[i] < -131072 || c[i] > 131071) exp_err = 1'b1;
      exp_e[i] = {18'(a[i]), 18'(b[i]), 18'(c[i])};
    end
  endfunction

  function automatic int field(input logic [53:0] w, input int k);
    logic signed [17:0] f;
    f = 18'(w >> (18 * (2 - k)));
    return int'(f);
  endfunction

  function automatic int eval_e(input logic [53:0] w, input int x, input int y);
    return field(w, 0) * x + field(w, 1) * y + field(w, 2);
  endfunction

  task automatic chk_outs(input string tag);
    chk({tag, "_e0"}, e0, cur_e[0]);
    chk({tag, "_e1"}, e1, cur_e[1]);
    chk({tag, "_e2"}, e2, cur_e[2]);
  endtask

  // One transfer; fs_early pulses frame_start in that busy cycle (0 = none),
  // hold_valid keeps in_valid high with scrambled inputs while busy.
  task automatic do_tri(input int x0, input int y0, input int x1, input int y1,
                        input int x2, input int y2, input int fs_early,
                        input bit hold_valid, input int wait_cycles);
    @(negedge clk);
    tx[0] = x0; ty[0] = y0; tx[1] = x1; ty[1] = y1; tx[2] = x2; ty[2] = y2;
    ref_model();
    in_x0 = XW'(x0); in_y0 = XW'(y0); in_x1 = XW'(x1);
    in_y1 = XW'(y1); in_x2 = XW'(x2); in_y2 = XW'(y2);
    in_valid = 1'b1;
    chk("ready_idle", in_ready, 1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      in_valid    = hold_valid;
      frame_start = (c == fs_early);
      if (hold_valid) begin
        in_x0 = XW'($urandom_range(0, 1023)); in_y1 = XW'($urandom_range(0, 1023));
        in_x2 = XW'($urandom_range(0, 1023)); in_y0 = XW'($urandom_range(0, 1023));
      end
      chk("busy_run", busy, 1);
      chk("ready_run", in_ready, 0);
      chk("upd_run", updated, 0);
      chk_outs("hold_run");
    end
    @(negedge clk);
    in_valid    = 1'b0;
    frame_start = 1'b0;
    chk("err_c9", err, exp_err);
    chk("upd_c9", updated, 0);
    if (exp_err) begin
      chk("ready_after_err", in_ready, 1);
      chk("busy_after_err", busy, 0);
      chk_outs("keep_err");
      @(negedge clk);
      chk("err_one_cycle", err, 0);
      chk_outs("keep_err2");
      return;
    end
    chk("busy_pend", busy, 1);
    chk("ready_pend", in_ready, 0);
    for (int w = 0; w < wait_cycles; w++) begin
      @(negedge clk);
      chk("busy_wait", busy, 1);
      chk("upd_wait", updated, 0);
      chk_outs("hold_wait");
    end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    if (exp_deg) begin
      cur_e[0] = NOHIT; cur_e[1] = '0; cur_e[2] = '0;
    end else begin
      cur_e = exp_e;
    end
    chk("upd_commit", updated, 1);
    chk("deg_commit", degenerate, exp_deg);
    chk("ready_commit", in_ready, 1);
    chk("busy_commit", busy, 0);
    chk_outs("commit");
    @(negedge clk);
    chk("upd_one_cycle", updated, 0);
    chk("deg_one_cycle", degenerate, 0);
  endtask

  initial begin
    vga_rst = 1'b1; in_valid = 1'b0; frame_start = 1'b0;
    in_x0 = '0; in_y0 = '0; in_x1 = '0; in_y1 = '0; in_x2 = '0; in_y2 = '0;
    cur_e[0] = NOHIT; cur_e[1] = '0; cur_e[2] = '0;
    repeat (3) @(negedge clk);
    vga_rst = 1'b0;
    chk("rst_e0", e0, 54'h00000_00000_3ffff);
    chk_outs("rst");
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_upd", updated, 0);
    chk("rst_err", err, 0);

    // Counter-clockwise reference triangle.
    do_tri(100, 100, 200, 100, 100, 200, 0, 1'b0, 2);
    chk("ccw_e0", e0, {18'h00000, 18'h00064, 18'h3D8F0});
    chk("ccw_e1", e1, {18'h3FF9C, 18'h3FF9C, 18'h07530});
    chk("ccw_e2", e2, {18'h00064, 18'h00000, 18'h3D8F0});
    chk("ccw_E0", eval_e(e0, 120, 120), 2000);
    chk("ccw_E1", eval_e(e1, 120, 120), 6000);
    chk("ccw_E2", eval_e(e2, 120, 120), 2000);

    // Reversed winding must be negated into the same orientation.
    do_tri(100, 100, 100, 200, 200, 100, 0, 1'b0, 0);
    chk("rev_e0", e0, {18'h00064, 18'h00000, 18'h3D8F0});
    chk("rev_E0_pos", eval_e(e0, 120, 120) >= 0, 1);
    chk("rev_E1_pos", eval_e(e1, 120, 120) >= 0, 1);
    chk("rev_E2_pos", eval_e(e2, 120, 120) >= 0, 1);

    // Out-of-range C1 is dropped; outputs retain the reversed result.
    do_tri(0, 0, 639, 0, 0, 479, 0, 1'b0, 0);
    chk("ovf_keep_e0", e0, {18'h00064, 18'h00000, 18'h3D8F0});

    // Collinear -> no-hit with degenerate.
    do_tri(0, 0, 10, 10, 20, 20, 0, 1'b0, 1);
    chk("col_e0", e0, 54'h00000_00000_3ffff);

    // frame_start while busy (cycle 4, and FIX cycle 8) is ignored.
    do_tri(50, 60, 300, 80, 120, 250, 4, 1'b0, 3);
    do_tri(10, 20, 200, 30, 40, 150, 8, 1'b0, 1);
    // in_valid held high while busy gives no second transfer.
    do_tri(5, 5, 250, 20, 30, 260, 0, 1'b1, 2);

    for (int n = 0; n < 30; n++) begin
      int x [3];
      int y [3];
      int lim;
      lim = (n % 5 == 0) ? 1023 : 300;
      for (int i = 0; i < 3; i++) begin
        x[i] = $urandom_range(0, lim);
        y[i] = $urandom_range(0, lim);
      end
      if (n % 7 == 3) begin
        x[1] = x[0]; y[1] = y[0];
      end
      do_tri(x[0], y[0], x[1], y[1], x[2], y[2], $urandom_range(0, 8),
             1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    // Reset in cycle 5 abandons the computation without a commit.
    @(negedge clk);
    in_x0 = 10'd10; in_y0 = 10'd10; in_x1 = 10'd200;
    in_y1 = 10'd20; in_x2 = 10'd30; in_y2 = 10'd150;
    in_valid = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    vga_rst = 1'b1;
    @(negedge clk);
    vga_rst = 1'b0;
    cur_e[0] = NOHIT; cur_e[1] = '0; cur_e[2] = '0;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_upd", updated, 0);
    chk_outs("mid_rst");
    repeat (10) @(negedge clk);
    chk("mid_rst_idle", busy, 0);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("mid_rst_no_commit", updated, 0);
    chk_outs("mid_rst_fs");

    do_tri(100, 100, 200, 100, 100, 200, 0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
